// File: rtl/imem_boot_sequencer.sv
// imem_boot_sequencer: sequences a single-port instruction memory through
// load, run and halt.
// - After reset it owns the memory write port.
// - It assembles little-endian host bytes into 32-bit words and writes them
//   from address 0 upward.
// - On the final word it releases the processor, and the memory address then
//   follows the program counter.
// - Halt and PC-range faults are reported, and a restart pulse returns the
//   block to IDLE.
// A byte is taken only when ld_valid and ld_ready are both high. ld_ready
// drops during the single write cycle that ends a load (final word or
// overflow), so no byte can be taken and then silently lost.
// Optional feature: define IMEM_SEQ_CHECKSUM_EN to require one XOR checksum
// word after the final program word before the processor is released.
module imem_boot_sequencer #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic [31:0]   cpu_pc,
  input  logic          cpu_halt,
  output logic          cpu_run,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_din,
  output logic [AW:0]   word_cnt,
  output logic          done,
  output logic          load_err,
  output logic          pc_fault
);

`ifdef IMEM_SEQ_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, RUN, HALTED, ERR, CHK} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, RUN, HALTED, ERR} state_t;
`endif

  localparam logic [AW:0]   LAST_ADDR = (AW+1)'(DEPTH - 1);
  localparam logic [31:0]   PC_LIMIT  = 32'(DEPTH);

  state_t       state;
  state_t       next_state;
  logic [1:0]   byte_idx;
  logic [23:0]  word_buf;
  logic         wr_pend;
  logic [31:0]  wr_data;
  logic         fin_pend;
  logic         ovf_pend;
  logic         accept;
  logic         take_word;
  logic         set_load_err;
  logic         set_pc_fault;
  logic         set_done;
  logic         do_restart;
`ifdef IMEM_SEQ_CHECKSUM_EN
  logic [31:0]  csum;
`endif

  assign accept    = ld_valid & ld_ready;
  assign take_word = accept && (byte_idx == 2'd3) && (state == LOAD);
  assign mem_we    = wr_pend;
  assign mem_din   = wr_data;

  // Next-state decode, handshake and address mux; status set/clear requests
  always_comb begin
    next_state   = state;
    ld_ready     = 1'b0;
    cpu_run      = 1'b0;
    mem_addr     = word_cnt[AW-1:0];
    set_load_err = 1'b0;
    set_pc_fault = 1'b0;
    set_done     = 1'b0;
    do_restart   = 1'b0;
    case (state)
      IDLE: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          if (ld_last) begin
            next_state   = ERR;
            set_load_err = 1'b1;
          end else begin
            next_state = LOAD;
          end
        end
      end
      LOAD: begin
        ld_ready = !(fin_pend || ovf_pend);
        if (fin_pend) begin
`ifdef IMEM_SEQ_CHECKSUM_EN
          next_state = CHK;
`else
          next_state = RUN;
`endif
        end else if (ovf_pend) begin
          next_state   = ERR;
          set_load_err = 1'b1;
        end else if (ld_valid && ld_last && (byte_idx != 2'd3)) begin
          next_state   = ERR;
          set_load_err = 1'b1;
        end
      end
`ifdef IMEM_SEQ_CHECKSUM_EN
      CHK: begin
        ld_ready = 1'b1;
        if (ld_valid && (byte_idx == 2'd3)) begin
          if ({ld_data, word_buf} == csum) begin
            next_state = RUN;
          end else begin
            next_state   = ERR;
            set_load_err = 1'b1;
          end
        end
      end
`endif
      RUN: begin
        cpu_run  = 1'b1;
        mem_addr = cpu_pc[AW-1:0];
        if (cpu_pc >= PC_LIMIT) begin
          next_state   = ERR;
          set_pc_fault = 1'b1;
        end else if (cpu_halt) begin
          next_state = HALTED;
          set_done   = 1'b1;
        end
      end
      HALTED, ERR: begin
        if (restart) begin
          next_state = IDLE;
          do_restart = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Byte assembly, write pipeline, word counter and sticky status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx <= 2'd0;
      word_buf <= 24'd0;
      wr_pend  <= 1'b0;
      wr_data  <= 32'd0;
      fin_pend <= 1'b0;
      ovf_pend <= 1'b0;
      word_cnt <= '0;
      done     <= 1'b0;
      load_err <= 1'b0;
      pc_fault <= 1'b0;
`ifdef IMEM_SEQ_CHECKSUM_EN
      csum     <= 32'd0;
`endif
    end else if (do_restart) begin
      byte_idx <= 2'd0;
      word_buf <= 24'd0;
      wr_pend  <= 1'b0;
      fin_pend <= 1'b0;
      ovf_pend <= 1'b0;
      word_cnt <= '0;
      done     <= 1'b0;
      load_err <= 1'b0;
      pc_fault <= 1'b0;
`ifdef IMEM_SEQ_CHECKSUM_EN
      csum     <= 32'd0;
`endif
    end else begin
      wr_pend  <= take_word;
      fin_pend <= take_word & ld_last;
      ovf_pend <= take_word & ~ld_last & (word_cnt == LAST_ADDR);
      if (accept) begin
        case (byte_idx)
          2'd0:    word_buf[7:0]   <= ld_data;
          2'd1:    word_buf[15:8]  <= ld_data;
          2'd2:    word_buf[23:16] <= ld_data;
          default: ;
        endcase
        byte_idx <= byte_idx + 2'd1;
      end
      if (take_word) wr_data <= {ld_data, word_buf};
      if (wr_pend) begin
        word_cnt <= word_cnt + 1'b1;
`ifdef IMEM_SEQ_CHECKSUM_EN
        csum     <= csum ^ wr_data;
`endif
      end
      if (set_load_err) load_err <= 1'b1;
      if (set_pc_fault) pc_fault <= 1'b1;
      if (set_done)     done     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Directed testbench for imem_boot_sequencer: load, run/halt, malformed load,
// overflow, PC fault and asynchronous reset mid-word. Under
// IMEM_SEQ_CHECKSUM_EN it also sends checksum words and a bad checksum.
module tb_imem_boot_sequencer;

  localparam int DEPTH = 128;
  localparam int AW    = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          restart = 1'b0;
  logic          ld_valid = 1'b0;
  logic [7:0]    ld_data = 8'd0;
  logic          ld_last = 1'b0;
  logic          ld_ready;
  logic [31:0]   cpu_pc = 32'd0;
  logic          cpu_halt = 1'b0;
  logic          cpu_run;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic [AW:0]   word_cnt;
  logic          done;
  logic          load_err;
  logic          pc_fault;

  int vectors = 0;
  int miscompares = 0;

  logic [AW-1:0] wq_addr[$];
  logic [31:0]   wq_data[$];

  logic [31:0] prog [8] = '{32'h10100000, 32'h0300001C, 32'h00A00093, 32'h00100113,
                            32'h002081B3, 32'h00310233, 32'hDEADBEEF, 32'h0000006F};

  imem_boot_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .cpu_pc(cpu_pc), .cpu_halt(cpu_halt), .cpu_run(cpu_run),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .word_cnt(word_cnt), .done(done), .load_err(load_err), .pc_fault(pc_fault)
  );

  always #5 clk = ~clk;

  // Record every memory write, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_din);
    end
  end

  function automatic logic [31:0] ovf_word(input int i);
    return {8'(i), 8'hA5, 8'(255 - i), 8'h3C};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, output logic acc);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    acc      = ld_ready;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last, output int nacc);
    logic a;
    nacc = 0;
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], last && (k == 3), a);
      if (a) nacc++;
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_ld_ready: got %0b expected 1", ld_ready); end
    vectors++; if ({cpu_run, mem_we, done, load_err, pc_fault} !== 5'b0) begin miscompares++; $display("[TB] FAIL rst_flags: got %b expected 00000", {cpu_run, mem_we, done, load_err, pc_fault}); end
    vectors++; if (word_cnt !== 8'd0 || mem_addr !== 7'd0 || mem_din !== 32'd0) begin miscompares++; $display("[TB] FAIL rst_values: got cnt=%0d addr=%0d din=%h expected 0", word_cnt, mem_addr, mem_din); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    vectors++; if (ld_ready !== 1'b1 || cpu_run !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_after_rst: got ready=%0b run=%0b expected 1/0", ld_ready, cpu_run); end
  endtask

  task automatic test_load();
    int n;
    int total;
    int bad;
    logic [31:0] x;
    wq_addr.delete();
    wq_data.delete();
    total = 0;
    x = 32'd0;
    for (int i = 0; i < 8; i++) begin
      send_word(prog[i], i == 7, n);
      total += n;
      x ^= prog[i];
    end
    vectors++; if (total != 32) begin miscompares++; $display("[TB] FAIL load_accepted: got %0d expected 32", total); end
    vectors++; if (mem_we !== 1'b1 || mem_addr !== 7'd7 || mem_din !== prog[7]) begin miscompares++; $display("[TB] FAIL load_last_write: got we=%0b addr=%0d din=%h expected 1/7/%h", mem_we, mem_addr, mem_din, prog[7]); end
    vectors++; if (cpu_run !== 1'b0) begin miscompares++; $display("[TB] FAIL load_run_early: got %0b expected 0", cpu_run); end
    tick();
`ifdef IMEM_SEQ_CHECKSUM_EN
    vectors++; if (cpu_run !== 1'b0 || ld_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL chk_wait: got run=%0b ready=%0b expected 0/1", cpu_run, ld_ready); end
    send_word(x, 1'b0, n);
`endif
    vectors++; if (cpu_run !== 1'b1 || mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL load_run: got run=%0b we=%0b expected 1/0", cpu_run, mem_we); end
    vectors++; if (word_cnt !== 8'd8) begin miscompares++; $display("[TB] FAIL load_word_cnt: got %0d expected 8", word_cnt); end
    bad = 0;
    if (wq_addr.size() != 8) bad = 99;
    else for (int i = 0; i < 8; i++) if (wq_addr[i] !== 7'(i) || wq_data[i] !== prog[i]) bad++;
    vectors++; if (bad != 0) begin miscompares++; $display("[TB] FAIL load_writes: got %0d writes with %0d bad expected 8 exact", wq_addr.size(), bad); end
  endtask

  task automatic test_run_halt();
    int pcs [4] = '{0, 1, 2, 7};
    for (int i = 0; i < 4; i++) begin
      cpu_pc = 32'(pcs[i]);
      #1;
      vectors++; if (mem_addr !== 7'(pcs[i]) || cpu_run !== 1'b1 || mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL run_addr_%0d: got addr=%0d run=%0b we=%0b expected %0d/1/0", i, mem_addr, cpu_run, mem_we, pcs[i]); end
      tick();
    end
    do_restart();
    vectors++; if (cpu_run !== 1'b1 || word_cnt !== 8'd8) begin miscompares++; $display("[TB] FAIL run_restart_ignored: got run=%0b cnt=%0d expected 1/8", cpu_run, word_cnt); end
    cpu_pc = 32'd7;
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    vectors++; if (cpu_run !== 1'b0 || done !== 1'b1 || pc_fault !== 1'b0) begin miscompares++; $display("[TB] FAIL halt: got run=%0b done=%0b fault=%0b expected 0/1/0", cpu_run, done, pc_fault); end
    tick();
    vectors++; if (done !== 1'b1 || ld_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL halt_hold: got done=%0b ready=%0b expected 1/0", done, ld_ready); end
    do_restart();
    vectors++; if (done !== 1'b0 || word_cnt !== 8'd0 || ld_ready !== 1'b1 || cpu_run !== 1'b0) begin miscompares++; $display("[TB] FAIL restart_idle: got done=%0b cnt=%0d ready=%0b run=%0b expected 0/0/1/0", done, word_cnt, ld_ready, cpu_run); end
  endtask

  task automatic test_early_last();
    int n;
    logic a;
    wq_addr.delete();
    wq_data.delete();
    send_word(32'hCAFEF00D, 1'b0, n);
    send_byte(8'h11, 1'b0, a);
    send_byte(8'h22, 1'b0, a);
    send_byte(8'h33, 1'b1, a);
    vectors++; if (load_err !== 1'b1 || ld_ready !== 1'b0 || cpu_run !== 1'b0) begin miscompares++; $display("[TB] FAIL early_last: got err=%0b ready=%0b run=%0b expected 1/0/0", load_err, ld_ready, cpu_run); end
    tick();
    tick();
    vectors++; if (wq_addr.size() != 1 || wq_data[0] !== 32'hCAFEF00D || mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL early_last_writes: got %0d writes expected 1 of cafef00d", wq_addr.size()); end
    send_byte(8'h44, 1'b0, a);
    vectors++; if (a !== 1'b0 || word_cnt !== 8'd1) begin miscompares++; $display("[TB] FAIL err_ignores_bytes: got acc=%0b cnt=%0d expected 0/1", a, word_cnt); end
    do_restart();
  endtask

  task automatic test_overflow();
    int n;
    int total;
    int bad;
    wq_addr.delete();
    wq_data.delete();
    total = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      send_word(ovf_word(i), 1'b0, n);
      total += n;
    end
    tick();
    vectors++; if (total != 4 * DEPTH) begin miscompares++; $display("[TB] FAIL ovf_accepted: got %0d expected %0d", total, 4 * DEPTH); end
    vectors++; if (load_err !== 1'b1 || ld_ready !== 1'b0 || cpu_run !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_err: got err=%0b ready=%0b run=%0b expected 1/0/0", load_err, ld_ready, cpu_run); end
    vectors++; if (word_cnt !== 8'd128) begin miscompares++; $display("[TB] FAIL ovf_word_cnt: got %0d expected 128", word_cnt); end
    bad = 0;
    if (wq_addr.size() != DEPTH) bad = 999;
    else for (int i = 0; i < DEPTH; i++) if (wq_addr[i] !== 7'(i) || wq_data[i] !== ovf_word(i)) bad++;
    vectors++; if (bad != 0) begin miscompares++; $display("[TB] FAIL ovf_writes: got %0d writes with %0d bad expected 128 exact", wq_addr.size(), bad); end
    do_restart();
  endtask

  task automatic test_pc_fault();
    int n;
    send_word(32'h0000006F, 1'b1, n);
    tick();
`ifdef IMEM_SEQ_CHECKSUM_EN
    send_word(32'h0000006F, 1'b0, n);
`endif
    cpu_pc = 32'd127;
    tick();
    vectors++; if (cpu_run !== 1'b1 || pc_fault !== 1'b0) begin miscompares++; $display("[TB] FAIL pc_127_ok: got run=%0b fault=%0b expected 1/0", cpu_run, pc_fault); end
    cpu_pc = 32'd128;
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    cpu_pc = 32'd0;
    vectors++; if (pc_fault !== 1'b1 || done !== 1'b0 || cpu_run !== 1'b0 || load_err !== 1'b0) begin miscompares++; $display("[TB] FAIL pc_fault: got fault=%0b done=%0b run=%0b err=%0b expected 1/0/0/0", pc_fault, done, cpu_run, load_err); end
    do_restart();
  endtask

  task automatic test_reset_mid();
    int n;
    logic a;
    for (int i = 0; i < 3; i++) send_word(prog[i], 1'b0, n);
    send_byte(8'hAA, 1'b0, a);
    send_byte(8'hBB, 1'b0, a);
    do_restart();
    vectors++; if (word_cnt !== 8'd3 || ld_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL load_restart_ignored: got cnt=%0d ready=%0b expected 3/1", word_cnt, ld_ready); end
    #2;
    reset = 1'b0;
    #1;
    vectors++; if (word_cnt !== 8'd0 || ld_ready !== 1'b1 || mem_addr !== 7'd0 || mem_din !== 32'd0) begin miscompares++; $display("[TB] FAIL mid_rst_values: got cnt=%0d ready=%0b addr=%0d din=%h expected 0/1/0/0", word_cnt, ld_ready, mem_addr, mem_din); end
    vectors++; if ({cpu_run, mem_we, done, load_err, pc_fault} !== 5'b0) begin miscompares++; $display("[TB] FAIL mid_rst_flags: got %b expected 00000", {cpu_run, mem_we, done, load_err, pc_fault}); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    send_word(32'h11223344, 1'b1, n);
    vectors++; if (mem_we !== 1'b1 || mem_addr !== 7'd0 || mem_din !== 32'h11223344) begin miscompares++; $display("[TB] FAIL reload_addr0: got we=%0b addr=%0d din=%h expected 1/0/11223344", mem_we, mem_addr, mem_din); end
    tick();
`ifdef IMEM_SEQ_CHECKSUM_EN
    send_word(32'h11223344, 1'b0, n);
`endif
    vectors++; if (cpu_run !== 1'b1 || word_cnt !== 8'd1) begin miscompares++; $display("[TB] FAIL reload_run: got run=%0b cnt=%0d expected 1/1", cpu_run, word_cnt); end
  endtask

`ifdef IMEM_SEQ_CHECKSUM_EN
  task automatic test_checksum_bad();
    int n;
    logic a;
    logic [31:0] bad_sum;
    reset = 1'b0;
    #3;
    @(negedge clk);
    reset = 1'b1;
    tick();
    send_word(prog[0], 1'b0, n);
    send_word(prog[1], 1'b1, n);
    tick();
    bad_sum = prog[0] ^ prog[1] ^ 32'h1;
    for (int k = 0; k < 4; k++) send_byte(bad_sum[8*k +: 8], k == 0, a);
    vectors++; if (load_err !== 1'b1 || cpu_run !== 1'b0 || ld_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL chk_bad: got err=%0b run=%0b ready=%0b expected 1/0/0", load_err, cpu_run, ld_ready); end
    vectors++; if (word_cnt !== 8'd2) begin miscompares++; $display("[TB] FAIL chk_bad_cnt: got %0d expected 2", word_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_run_halt();
    test_early_last();
    test_overflow();
    test_pc_fault();
    test_reset_mid();
`ifdef IMEM_SEQ_CHECKSUM_EN
    test_checksum_bad();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
